t05_hist_rmw_engine: RTL
========================

# t05_hist_rmw_engine

Parametrised histogram builder for the Huffman front end. Consumes a symbol stream through a valid/ready handshake and, for each symbol, performs a read-modify-write increment of that symbol's bin in SRAM through a req/ack memory port. It counts total symbols, saturates bin and total counts at full scale, and stops after the end-of-file symbol. It sits between the SPI byte receiver and the SRAM arbiter, ahead of the Huffman tree builder.

## Interface
Parameters:
- SYM_W, 8: symbol width; bins = 2**SYM_W
- CNT_W, 32: bin-count and total width
- ADDR_W, 10: memory address width; must satisfy ADDR_W >= SYM_W
- BASE_ADDR, 0: address of bin 0; bin k at BASE_ADDR + k (modulo 2**ADDR_W)
- EOF_SYM, 8'h1A: terminating symbol (SYM_W bits)

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse that begins a run; ignored unless busy_o=0
- sym_i  in  SYM_W  input symbol
- sym_valid_i  in  1  sym_i valid
- sym_ready_o  out  1  engine accepts sym_i this cycle
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1=write, 0=read
- mem_addr_o  out  ADDR_W  bin address
- mem_wdata_o  out  CNT_W  write data
- mem_rdata_i  in  CNT_W  read data, valid in the ack cycle of a read
- mem_ack_i  in  1  completes the current request
- total_o  out  CNT_W  symbols accepted this run, EOF included
- busy_o  out  1  run in progress
- done_o  out  1  run finished; held until next start or rst
- sat_o  out  1  sticky; a bin or the total saturated this run

## Operation
- States: IDLE, CLEAR, ACCEPT, RD, WR, DONE.
- IDLE:
  - busy_o=0; sym_ready_o=0.
  - On start: clear total_o, sat_o and done_o; go to CLEAR if the macro is defined, otherwise go to ACCEPT.
  - done_o stays high in IDLE/DONE until start.
- CLEAR:
  - Issues writes of 0 to bins 0..2**SYM_W-1 in ascending order, one write per ack.
  - The ack of the last bin moves to ACCEPT.
- ACCEPT:
  - sym_ready_o=1.
  - On sym_valid_i: capture sym_i into sym_q; set eof_q = (sym_i==EOF_SYM); total_o += 1, saturating at 2**CNT_W-1 (sets sat_o); go to RD.
- RD:
  - Read request: mem_req_o=1, mem_we_o=0, mem_addr_o=BASE_ADDR+sym_q.
  - On ack: set wdata_q = mem_rdata_i+1, or hold at 2**CNT_W-1 if mem_rdata_i is already all ones (sets sat_o); go to WR.
- WR:
  - Write request: mem_req_o=1, mem_we_o=1, same address, mem_wdata_o=wdata_q.
  - On ack: go to DONE if eof_q, otherwise go to ACCEPT.
- DONE: done_o=1, busy_o=0; start begins a new run.
- Handshake rules:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable from assertion until the cycle mem_ack_i is sampled high.
  - An ack is accepted in the first cycle req is high.
  - mem_ack_i while mem_req_o=0 is ignored.
- sym_valid_i outside ACCEPT is not consumed; the source holds the symbol.
- The EOF symbol is itself binned and counted before DONE.
- start while busy_o=1 is ignored.

## Timing
- All outputs are registered.
- Reset values: sym_ready_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, total_o=0, busy_o=0, done_o=0, sat_o=0; state=IDLE.
- start at cycle n: busy_o=1 at n+1; mem_req_o (CLEAR) or sym_ready_o (ACCEPT) at n+1.
- Per-symbol throughput with zero-wait ack: 3 cycles (ACCEPT, RD, WR); each wait cycle on ack adds one.
- total_o updates the cycle after the accept.
- done_o rises the cycle after the write ack of EOF.
- rst mid-operation returns everything to reset values immediately. Any outstanding memory request is abandoned and bin contents are undefined.

## Configuration
- T05_HIST_CLEAR_EN defined: CLEAR state is present; every run starts by zeroing all 2**SYM_W bins (2**SYM_W writes).
- T05_HIST_CLEAR_EN undefined: CLEAR is absent; start goes directly to ACCEPT and bins accumulate onto existing SRAM contents (the system software preloads zeros).

## Test plan
- Basic: defaults, macro off, zero-wait memory model preloaded with 0; stream 'A','B','A',8'h1A.
  - Bins 0x41=2, 0x42=1, 0x1A=1; total_o=4; done_o high; 12 cycles from first accept to done.
- Clear: macro on, memory prefilled with 0xFFFF_FFFF; start.
  - Exactly 256 writes of 0 to addresses 0..255, then sym_ready_o=1.
- Back-pressure: memory ack delayed 3 cycles per request.
  - Address, we and wdata stable throughout each request; results identical to the basic test.
  - sym_valid_i held high is not consumed outside ACCEPT.
- Saturation: CNT_W=4, bin 0x05 preloaded with 15; feed 0x05 then EOF.
  - Bin stays 15; sat_o=1; total_o=2.
- Parameters: SYM_W=4, BASE_ADDR=10'h100, EOF_SYM=4'hF; feed 0x3, 0xF.
  - Writes to 0x103 and 0x10F only.
- Reset and start mid-run: assert rst during RD.
  - Outputs return to reset values the same cycle.
  - start while busy_o=1 leaves state and total_o unchanged.

Source files
------------

// File: rtl/t05_hist_rmw_engine_if.sv
// t05_hist_rmw_engine_if
// Purpose: bundles the symbol-stream handshake and the SRAM req/ack port of
//          the histogram engine.
// Modports:
//   master - engine side: consumes the symbol stream, drives memory requests
//   slave  - environment side: symbol source plus SRAM arbiter
// Signals:
//   sym_i        symbol from the byte receiver
//   sym_valid_i  sym_i valid
//   sym_ready_o  engine accepts sym_i this cycle
//   mem_req_o    memory request
//   mem_we_o     1 = write, 0 = read
//   mem_addr_o   bin address
//   mem_wdata_o  write data
//   mem_rdata_i  read data, valid in the ack cycle of a read
//   mem_ack_i    completes the current request
`timescale 1ns/1ps
interface t05_hist_rmw_engine_if #(
    parameter int SYM_W  = 8,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 10
) ();
    logic [SYM_W-1:0]  sym_i;
    logic              sym_valid_i;
    logic              sym_ready_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [CNT_W-1:0]  mem_wdata_o;
    logic [CNT_W-1:0]  mem_rdata_i;
    logic              mem_ack_i;

    modport master (
        input  sym_i, sym_valid_i, mem_rdata_i, mem_ack_i,
        output sym_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output sym_i, sym_valid_i, mem_rdata_i, mem_ack_i,
        input  sym_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/t05_hist_rmw_engine.sv
// t05_hist_rmw_engine
// Purpose: histogram builder for the Huffman front end. Each accepted symbol
//          triggers a read-modify-write increment of its SRAM bin. Bin and
//          total counts saturate at full scale; the run stops after the
//          end-of-file symbol has itself been binned.
// Build option: T05_HIST_CLEAR_EN - when defined, every run first zeroes all
//          2**SYM_W bins; when undefined, bins accumulate onto the SRAM
//          contents left by software.
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   start    one-cycle pulse starting a run (ignored while busy_o=1)
//   bus      symbol handshake + memory port (master modport)
//   total_o  symbols accepted this run, EOF included
//   busy_o   run in progress
//   done_o   run finished; held until next start or rst
//   sat_o    sticky: a bin or the total saturated this run
// All outputs are registered.
`timescale 1ns/1ps
module t05_hist_rmw_engine #(
    parameter int                SYM_W     = 8,
    parameter int                CNT_W     = 32,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [SYM_W-1:0]  EOF_SYM   = SYM_W'(8'h1A)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    t05_hist_rmw_engine_if.master bus,
    output logic [CNT_W-1:0]      total_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sat_o
);

    // state  | meaning
    // IDLE   | waiting for start after reset
    // CLEAR  | zeroing bins, one write per ack (T05_HIST_CLEAR_EN only)
    // ACCEPT | sym_ready_o high, waiting for a symbol
    // RD     | reading the bin of the captured symbol
    // WR     | writing the incremented bin back
    // DONE   | EOF binned; done_o held until next start
    typedef enum logic [2:0] {
        S_IDLE,
`ifdef T05_HIST_CLEAR_EN
        S_CLEAR,
`endif
        S_ACCEPT,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_eof;
`ifdef T05_HIST_CLEAR_EN
    logic [SYM_W-1:0]  r_clr_left;
`endif
    logic [ADDR_W-1:0] w_sym_addr;

    // Bin address wraps modulo 2**ADDR_W.
    assign w_sym_addr = BASE_ADDR + ADDR_W'(bus.sym_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_eof           <= 1'b0;
`ifdef T05_HIST_CLEAR_EN
            r_clr_left      <= '0;
`endif
            bus.sym_ready_o <= 1'b0;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            total_o         <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            sat_o           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        total_o <= '0;
                        sat_o   <= 1'b0;
                        done_o  <= 1'b0;
                        busy_o  <= 1'b1;
`ifdef T05_HIST_CLEAR_EN
                        r_state         <= S_CLEAR;
                        r_clr_left      <= '1;
                        bus.mem_req_o   <= 1'b1;
                        bus.mem_we_o    <= 1'b1;
                        bus.mem_addr_o  <= BASE_ADDR;
                        bus.mem_wdata_o <= '0;
`else
                        r_state         <= S_ACCEPT;
                        bus.sym_ready_o <= 1'b1;
`endif
                    end
                end
`ifdef T05_HIST_CLEAR_EN
                S_CLEAR: begin
                    // Request stays asserted across bins; only the address
                    // advances, and only on an ack.
                    if (bus.mem_ack_i) begin
                        if (r_clr_left == '0) begin
                            r_state         <= S_ACCEPT;
                            bus.mem_req_o   <= 1'b0;
                            bus.mem_we_o    <= 1'b0;
                            bus.sym_ready_o <= 1'b1;
                        end else begin
                            r_clr_left     <= r_clr_left - SYM_W'(1);
                            bus.mem_addr_o <= bus.mem_addr_o + ADDR_W'(1);
                        end
                    end
                end
`endif
                S_ACCEPT: begin
                    if (bus.sym_valid_i) begin
                        r_state         <= S_RD;
                        r_eof           <= (bus.sym_i == EOF_SYM);
                        bus.sym_ready_o <= 1'b0;
                        bus.mem_req_o   <= 1'b1;
                        bus.mem_we_o    <= 1'b0;
                        bus.mem_addr_o  <= w_sym_addr;
                        if (total_o == '1) begin
                            sat_o <= 1'b1;
                        end else begin
                            total_o <= total_o + CNT_W'(1);
                        end
                    end
                end
                S_RD: begin
                    // mem_req_o is high in RD, so any ack here belongs to us.
                    if (bus.mem_ack_i) begin
                        r_state      <= S_WR;
                        bus.mem_we_o <= 1'b1;
                        if (bus.mem_rdata_i == '1) begin
                            bus.mem_wdata_o <= '1;
                            sat_o           <= 1'b1;
                        end else begin
                            bus.mem_wdata_o <= bus.mem_rdata_i + CNT_W'(1);
                        end
                    end
                end
                S_WR: begin
                    if (bus.mem_ack_i) begin
                        bus.mem_req_o <= 1'b0;
                        bus.mem_we_o  <= 1'b0;
                        if (r_eof) begin
                            r_state <= S_DONE;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            r_state         <= S_ACCEPT;
                            bus.sym_ready_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
